// File: rtl/keccak_pkg.sv
// Shared constants, state encoding and the rc(t) LFSR helpers for the Keccak round controller.
package keccak_pkg;

  localparam int unsigned KECCAK_ROUNDS = 24;
  localparam int unsigned ROUND_W       = 5;
  localparam int unsigned LANE_W        = 64;
  // x^8+x^6+x^5+x^4+1 without the x^8 term, as the feedback mask of a left shift
  localparam logic [7:0]  LFSR_POLY     = 8'h71;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_RUN
  } ctrl_state_e;

  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? LFSR_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] lfsr_step7(input logic [7:0] r);
    logic [7:0] s;
    s = r;
    for (int unsigned k = 0; k < 7; k++) s = lfsr_step(s);
    return s;
  endfunction

  function automatic logic [7:0] lfsr_seed(input int unsigned first_round);
    logic [7:0] s;
    s = 8'h01;
    for (int unsigned k = 0; k < first_round; k++) s = lfsr_step7(s);
    return s;
  endfunction

  // Bit 2^j-1 of the lane carries rc(7i+j); R[0] is rc(7i), later bits come from unrolled steps.
  function automatic logic [LANE_W-1:0] rc_expand(input logic [7:0] r);
    logic [7:0]        s;
    logic [LANE_W-1:0] c;
    s = r;
    c = '0;
    for (int unsigned j = 0; j < 7; j++) begin
      c = c | (LANE_W'(s[0]) << ((32'd1 << j) - 32'd1));
      s = lfsr_step(s);
    end
    return c;
  endfunction

endpackage

// File: rtl/keccak_rc_lfsr.sv
// 8-bit rc(t) LFSR: seed load, 7-step advance per round, expanded 64-bit iota constant.
module keccak_rc_lfsr
  import keccak_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_advance,
  output logic [LANE_W-1:0] o_rc
);

  logic [7:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_lfsr <= SEED;
    else if (i_load)    r_lfsr <= SEED;
    else if (i_advance) r_lfsr <= lfsr_step7(r_lfsr);
  end

  assign o_rc = rc_expand(r_lfsr);

endmodule

// File: rtl/keccak_round_ctrl.sv
// Round sequencer for an iterated Keccak-f[1600] datapath: round index, iota constant,
// back-pressure via stall, and a one-cycle done pulse after the final round is consumed.
module keccak_round_ctrl
  import keccak_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic               stall,
  output logic               round_valid,
  output logic [ROUND_W-1:0] round_idx,
  output logic [LANE_W-1:0]  rc,
  output logic               last_round,
  output logic               done
);

  localparam int unsigned        FIRST_ROUND = KECCAK_ROUNDS - NUM_ROUNDS;
  localparam logic [7:0]         LFSR_SEED   = lfsr_seed(FIRST_ROUND);
  localparam logic [ROUND_W-1:0] FIRST_IDX   = ROUND_W'(FIRST_ROUND);
  localparam logic [ROUND_W-1:0] LAST_IDX    = ROUND_W'(KECCAK_ROUNDS - 1);

  ctrl_state_e        r_state, w_state_nxt;
  logic [ROUND_W-1:0] r_round;
  logic               r_done;
  logic               w_accept;
  logic               w_advance;
  logic               w_last;
  logic [LANE_W-1:0]  w_rc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    round_valid = 1'b0;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        round_valid = 1'b1;
        if (!stall) begin
          w_advance = 1'b1;
          if (r_round == LAST_IDX) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_last = round_valid && (r_round == LAST_IDX);

  // Index returns to 0 after the final round so it never steps past 23.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_advance && w_last;
      if (w_accept)       r_round <= FIRST_IDX;
      else if (w_advance) r_round <= w_last ? '0 : r_round + 5'd1;
    end
  end

  keccak_rc_lfsr #(
    .SEED(LFSR_SEED)
  ) u_rc_lfsr (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_advance (w_advance),
    .o_rc      (w_rc)
  );

  assign round_idx  = r_round;
  assign rc         = round_valid ? w_rc : '0;
  assign last_round = w_last;
  assign done       = r_done;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Bench for keccak_round_ctrl: a 24-round and a 12-round instance share stimulus and are checked
// every cycle against a behavioural model built on the FIPS 202 rc(t) definition.
module tb_keccak_round_ctrl;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;

  logic        rdy  [2];
  logic        vld  [2];
  logic [4:0]  idx  [2];
  logic [63:0] rco  [2];
  logic        last [2];
  logic        done [2];

  int n_cmp = 0;
  int n_bad = 0;

  int m_busy  [2];
  int m_round [2];
  int m_done  [2];
  int first   [2] = '{0, 12};

  always #5 clk = ~clk;

  keccak_round_ctrl #(.NUM_ROUNDS(24)) dut24 (
    .clk(clk), .rst(rst), .start(start), .ready(rdy[0]), .stall(stall),
    .round_valid(vld[0]), .round_idx(idx[0]), .rc(rco[0]), .last_round(last[0]), .done(done[0])
  );

  keccak_round_ctrl #(.NUM_ROUNDS(12)) dut12 (
    .clk(clk), .rst(rst), .start(start), .ready(rdy[1]), .stall(stall),
    .round_valid(vld[1]), .round_idx(idx[1]), .rc(rco[1]), .last_round(last[1]), .done(done[1])
  );

  task automatic chk(input string name, input int n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[inst%0d] @%0t: got %h, expected %h", name, n, $time, act, exp);
    end
  endtask

  // rc(t) straight from FIPS 202 Algorithm 5, 9-entry bit array with R[0] first.
  function automatic int rc_bit(input int t);
    int r [9];
    int tm;
    tm = t % 255;
    if (tm == 0) return 1;
    r = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 1; i <= tm; i++) begin
      for (int k = 8; k > 0; k--) r[k] = r[k-1];
      r[0] = 0;
      r[0] = r[0] ^ r[8];
      r[4] = r[4] ^ r[8];
      r[5] = r[5] ^ r[8];
      r[6] = r[6] ^ r[8];
    end
    return r[0];
  endfunction

  function automatic logic [63:0] rc_const(input int i);
    logic [63:0] c;
    c = '0;
    for (int j = 0; j < 7; j++) c = c | (64'(rc_bit(7 * i + j)) << ((2 ** j) - 1));
    return c;
  endfunction

  // Inputs only change between a rising edge and the following falling edge,
  // so at the falling edge they are exactly what the next rising edge samples.
  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        m_busy[n]  = 0;
        m_round[n] = 0;
        m_done[n]  = 0;
      end
      chk("ready", n, 64'(rdy[n]), 64'(m_busy[n] == 0));
      chk("round_valid", n, 64'(vld[n]), 64'(m_busy[n] != 0));
      if (m_busy[n] != 0) chk("round_idx", n, 64'(idx[n]), 64'(m_round[n]));
      chk("rc", n, rco[n], (m_busy[n] != 0) ? rc_const(m_round[n]) : 64'h0);
      chk("last_round", n, 64'(last[n]), 64'((m_busy[n] != 0) && (m_round[n] == 23)));
      chk("done", n, 64'(done[n]), 64'(m_done[n]));
      if (!rst) begin
        m_done[n] = 0;
        if (m_busy[n] != 0) begin
          if (!stall) begin
            if (m_round[n] == 23) begin
              m_busy[n]  = 0;
              m_done[n]  = 1;
              m_round[n] = 0;
            end else begin
              m_round[n] = m_round[n] + 1;
            end
          end
        end else if (start) begin
          m_busy[n]  = 1;
          m_round[n] = first[n];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idx(input logic [4:0] v);
    for (int k = 0; k < 60 && idx[0] !== v; k++) step();
    chk("reach_idx", 0, 64'(idx[0]), 64'(v));
  endtask

  task automatic wait_done();
    for (int k = 0; k < 80 && done[0] !== 1'b1; k++) step();
    chk("reach_done", 0, 64'(done[0]), 64'h1);
  endtask

  initial begin
    int d24, d12, cyc, ndone;

    chk("model_rc0",  0, rc_const(0),  64'h0000000000000001);
    chk("model_rc1",  0, rc_const(1),  64'h0000000000008082);
    chk("model_rc2",  0, rc_const(2),  64'h800000000000808A);
    chk("model_rc5",  0, rc_const(5),  64'h0000000080000001);
    chk("model_rc6",  0, rc_const(6),  64'h8000000080008081);
    chk("model_rc12", 0, rc_const(12), 64'h000000008000808B);
    chk("model_rc23", 0, rc_const(23), 64'h8000000080008008);

    // Reset values
    step(); step(); step();
    chk("rst_ready", 0, 64'(rdy[0]), 64'h1);
    chk("rst_valid", 0, 64'(vld[0]), 64'h0);
    chk("rst_rc",    0, rco[0],      64'h0);
    chk("rst_done",  0, 64'(done[0]), 64'h0);
    rst = 1'b0;
    step(); step();

    // Full run, latency of first round and done for both instances
    start = 1'b1;
    step();
    start = 1'b0;
    chk("first_idx", 0, 64'(idx[0]), 64'd0);
    chk("first_rc",  0, rco[0],      64'h1);
    chk("first_idx", 1, 64'(idx[1]), 64'd12);
    chk("first_rc",  1, rco[1],      64'h000000008000808B);
    cyc = 1; d24 = 0; d12 = 0;
    for (int k = 0; k < 40 && (d24 == 0 || d12 == 0); k++) begin
      if (done[0] && d24 == 0) d24 = cyc;
      if (done[1] && d12 == 0) d12 = cyc;
      if (d24 == 0 || d12 == 0) begin
        step();
        cyc++;
      end
    end
    chk("done_cycle", 0, 64'(d24), 64'd25);
    chk("done_cycle", 1, 64'(d12), 64'd13);
    step();

    // Stall held for three edges on round 5
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idx(5'd5);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("stall_idx", 0, 64'(idx[0]), 64'd5);
      chk("stall_rc",  0, rco[0],      64'h0000000080000001);
      if (k == 3) stall = 1'b0;
      step();
    end
    chk("after_stall_idx", 0, 64'(idx[0]), 64'd6);
    chk("after_stall_rc",  0, rco[0],      64'h8000000080008081);
    wait_done();
    step();

    // Reset in the middle of a run
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idx(5'd10);
    #1 rst = 1'b1;
    #1;
    chk("abort_ready", 0, 64'(rdy[0]), 64'h1);
    chk("abort_valid", 0, 64'(vld[0]), 64'h0);
    chk("abort_idx",   0, 64'(idx[0]), 64'h0);
    chk("abort_rc",    0, rco[0],      64'h0);
    chk("abort_done",  0, 64'(done[0]), 64'h0);
    step();
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_idx", 0, 64'(idx[0]), 64'd0);
    chk("restart_rc",  0, rco[0],      64'h1);

    // start in the done cycle is accepted; start during a run is ignored
    wait_done();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("bt_valid", 0, 64'(vld[0]), 64'h1);
    chk("bt_idx",   0, 64'(idx[0]), 64'd0);
    chk("bt_done",  0, 64'(done[0]), 64'h0);
    step(); step(); step();
    start = 1'b1;
    step(); step(); step();
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done[0]) ndone++;
      step();
    end
    chk("single_done", 0, 64'(ndone), 64'd1);

    // Randomised traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 2) == 0);
      step();
    end
    rst   = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
